// File: rtl/jtframe_ioctl_split.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_ioctl_split
// Brief    : Serialises DW_IN-bit HPS ioctl words into spaced byte writes
//            and routes them to ROM, DIP-switch or core-mode targets.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_ioctl_split #(
    parameter int         DW_IN   = 16,
    parameter int         GAP     = 24,
    parameter int         DIPW    = 4,
    parameter int         MODW    = 7,
    parameter logic [7:0] ROM_IDX = 8'd0,
    parameter logic [7:0] MOD_IDX = 8'd1,
    parameter logic [7:0] DIP_IDX = 8'd254
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr_in,
    input  logic [26:0]         ioctl_addr_in,
    input  logic [DW_IN-1:0]    ioctl_data_in,
    output logic                rom_wr,
    output logic [24:0]         rom_addr,
    output logic [7:0]          rom_data,
    output logic [8*DIPW-1:0]   dipsw,
    output logic [MODW-1:0]     core_mod,
    output logic                busy,
    output logic                overrun
);

    localparam int          c_nb     = DW_IN / 8;
    localparam int          c_aw     = (c_nb > 2) ? 2 : ((c_nb > 1) ? 1 : 0);
    localparam logic [26:0] c_amask  = ~((27'd1 << c_aw) - 27'd1);
    localparam logic [15:0] c_gap_rl = 16'(GAP - 1);
    localparam logic [2:0]  c_nb_k   = 3'(c_nb);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DW_IN-1:0]   data_q, data_d;
    logic [7:0]         idx_q, idx_d;
    logic [26:0]        addr_q, addr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2:0]         k_q, k_d;
    logic               pulse_q, pulse_d;
    logic [7:0]         pidx_q, pidx_d;
    logic [26:0]        paddr_q, paddr_d;
    logic [7:0]         pbyte_q, pbyte_d;
    logic               rom_wr_q, rom_wr_d;
    logic [24:0]        rom_addr_q, rom_addr_d;
    logic [7:0]         rom_data_q, rom_data_d;
    logic [8*DIPW-1:0]  dip_q, dip_d;
    logic [MODW-1:0]    mod_q, mod_d;
    logic               ovr_q, ovr_d;
    logic               dl_q, dl_d;

    logic               w_emit;
    logic               w_ovr_set;
    logic [7:0]         w_eidx;
    logic [26:0]        w_eaddr;
    logic [7:0]         w_ebyte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            pulse_q    <= 1'b0;
            pidx_q     <= '0;
            paddr_q    <= '0;
            pbyte_q    <= '0;
            rom_wr_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            dip_q      <= '1;
            mod_q      <= MODW'(1);
            ovr_q      <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            pulse_q    <= pulse_d;
            pidx_q     <= pidx_d;
            paddr_q    <= paddr_d;
            pbyte_q    <= pbyte_d;
            rom_wr_q   <= rom_wr_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            dip_q      <= dip_d;
            mod_q      <= mod_d;
            ovr_q      <= ovr_d;
            dl_q       <= dl_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        pulse_d    = 1'b0;
        pidx_d     = pidx_q;
        paddr_d    = paddr_q;
        pbyte_d    = pbyte_q;
        rom_wr_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        dip_d      = dip_q;
        mod_d      = mod_q;
        ovr_d      = ovr_q;
        dl_d       = ioctl_download;
        w_emit     = 1'b0;
        w_ovr_set  = 1'b0;
        w_eidx     = idx_q;
        w_eaddr    = addr_q;
        w_ebyte    = data_q[7:0];

        case (state_q)
            ST_IDLE: begin
                if (ioctl_wr_in) begin
                    w_emit  = 1'b1;
                    w_eidx  = ioctl_index;
                    w_eaddr = ioctl_addr_in & c_amask;
                    w_ebyte = ioctl_data_in[7:0];
                    idx_d   = ioctl_index;
                    addr_d  = (ioctl_addr_in & c_amask) + 27'd1;
                    data_d  = ioctl_data_in >> 8;
                    cnt_d   = c_gap_rl;
                    k_d     = 3'd1;
                    if (c_nb > 1) begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                w_ovr_set = ioctl_wr_in;
                // k_q reaches B in the cycle carrying the last pulse
                if (k_q == c_nb_k) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'd0) begin
                    w_emit = 1'b1;
                    addr_d = addr_q + 27'd1;
                    data_d = data_q >> 8;
                    cnt_d  = c_gap_rl;
                    k_d    = k_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_emit) begin
            pulse_d = 1'b1;
            pidx_d  = w_eidx;
            paddr_d = w_eaddr;
            pbyte_d = w_ebyte;
            if (w_eidx == ROM_IDX) begin
                rom_wr_d   = 1'b1;
                rom_addr_d = w_eaddr[24:0];
                rom_data_d = w_ebyte;
            end
        end

        // Register targets update from the delayed byte pulse
        if (pulse_q && (pidx_q == DIP_IDX)) begin
            for (int n = 0; n < DIPW; n++) begin
                if (paddr_q == 27'(n)) begin
                    dip_d[8*n +: 8] = pbyte_q;
                end
            end
        end
        if (pulse_q && (pidx_q == MOD_IDX) && (paddr_q == 27'd0)) begin
            mod_d = pbyte_q[MODW-1:0];
        end

        if (ioctl_download && !dl_q) begin
            ovr_d = 1'b0;
        end
        if (w_ovr_set) begin
            ovr_d = 1'b1;
        end
    end

    assign rom_wr   = rom_wr_q;
    assign rom_addr = rom_addr_q;
    assign rom_data = rom_data_q;
    assign dipsw    = dip_q;
    assign core_mod = mod_q;
    assign busy     = (state_q == ST_SEND);
    assign overrun  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_ioctl_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_ioctl_split
// Brief    : Scoreboard bench driving three configurations of the splitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_ioctl_split;

    typedef struct {
        int          dut;
        int          cyc;
        logic [24:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        download = 1'b1;
    logic [7:0]  index = 8'd0;
    logic        wr_in = 1'b0;
    logic [26:0] addr_in = '0;
    logic [31:0] data_in = '0;

    logic        rom_wr_o   [3];
    logic [24:0] rom_addr_o [3];
    logic [7:0]  rom_data_o [3];
    logic [31:0] dipsw_o    [3];
    logic [6:0]  core_mod_o [3];
    logic        busy_o     [3];
    logic        overrun_o  [3];

    int          nb [3] = '{2, 4, 4};
    int          gp [3] = '{24, 2, 24};
    int          bst  [3];
    int          bend [3];
    logic [31:0] dip_exp [3];
    logic [6:0]  mod_exp [3];
    logic        ov_exp  [3];
    exp_t        sb [$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jtframe_ioctl_split #(.DW_IN(16), .GAP(24)) u_dut_a (
        .clk(clk), .rst(rst), .ioctl_download(download), .ioctl_index(index),
        .ioctl_wr_in(wr_in), .ioctl_addr_in(addr_in), .ioctl_data_in(data_in[15:0]),
        .rom_wr(rom_wr_o[0]), .rom_addr(rom_addr_o[0]), .rom_data(rom_data_o[0]),
        .dipsw(dipsw_o[0]), .core_mod(core_mod_o[0]), .busy(busy_o[0]),
        .overrun(overrun_o[0])
    );

    jtframe_ioctl_split #(.DW_IN(32), .GAP(2)) u_dut_b (
        .clk(clk), .rst(rst), .ioctl_download(download), .ioctl_index(index),
        .ioctl_wr_in(wr_in), .ioctl_addr_in(addr_in), .ioctl_data_in(data_in),
        .rom_wr(rom_wr_o[1]), .rom_addr(rom_addr_o[1]), .rom_data(rom_data_o[1]),
        .dipsw(dipsw_o[1]), .core_mod(core_mod_o[1]), .busy(busy_o[1]),
        .overrun(overrun_o[1])
    );

    jtframe_ioctl_split #(.DW_IN(32), .GAP(24)) u_dut_c (
        .clk(clk), .rst(rst), .ioctl_download(download), .ioctl_index(index),
        .ioctl_wr_in(wr_in), .ioctl_addr_in(addr_in), .ioctl_data_in(data_in),
        .rom_wr(rom_wr_o[2]), .rom_addr(rom_addr_o[2]), .rom_data(rom_data_o[2]),
        .dipsw(dipsw_o[2]), .core_mod(core_mod_o[2]), .busy(busy_o[2]),
        .overrun(overrun_o[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
        end
    endtask

    // Per-cycle monitor: pulse timing, payload and busy window
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int   j;
            logic exp_pulse;
            j = -1;
            for (int m = 0; m < sb.size(); m++) begin
                if (j < 0 && sb[m].dut == i) j = m;
            end
            exp_pulse = (j >= 0) && (sb[j].cyc == cyc);
            chk($sformatf("rom_wr[%0d]", i), 32'(rom_wr_o[i]), 32'(exp_pulse));
            if (exp_pulse) begin
                chk($sformatf("rom_addr[%0d]", i), 32'(rom_addr_o[i]), 32'(sb[j].addr));
                chk($sformatf("rom_data[%0d]", i), 32'(rom_data_o[i]), 32'(sb[j].data));
                sb.delete(j);
            end else if (j >= 0 && sb[j].cyc < cyc) begin
                sb.delete(j);
            end
            chk($sformatf("busy[%0d]", i), 32'(busy_o[i]),
                32'((cyc >= bst[i]) && (cyc <= bend[i])));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            bst[i]     = 0;
            bend[i]    = -1;
            dip_exp[i] = 32'hFFFF_FFFF;
            mod_exp[i] = 7'h01;
            ov_exp[i]  = 1'b0;
        end
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // One-cycle strobe; expected effects are computed here per configuration
    task automatic strobe(input logic [7:0] idx, input logic [26:0] a, input logic [31:0] d);
        index   = idx;
        addr_in = a;
        data_in = d;
        wr_in   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (cyc >= bst[i] && cyc <= bend[i]) begin
                ov_exp[i] = 1'b1;
            end else begin
                logic [26:0] base;
                base    = a & ~(27'(nb[i]) - 27'd1);
                bst[i]  = cyc + 1;
                bend[i] = cyc + 1 + (nb[i] - 1) * gp[i];
                for (int k = 0; k < nb[i]; k++) begin
                    logic [26:0] ba;
                    logic [7:0]  by;
                    exp_t        e;
                    ba = base + 27'(k);
                    by = 8'(d >> (8 * k));
                    if (idx == 8'd0) begin
                        e.dut  = i;
                        e.cyc  = cyc + 1 + k * gp[i];
                        e.addr = ba[24:0];
                        e.data = by;
                        sb.push_back(e);
                    end else if (idx == 8'd254) begin
                        if (ba < 27'd4) dip_exp[i][8*ba[1:0] +: 8] = by;
                    end else if (idx == 8'd1) begin
                        if (ba == 27'd0) mod_exp[i] = by[6:0];
                    end
                end
            end
        end
        tick(1);
        wr_in = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s dipsw[%0d]", tag, i), dipsw_o[i], dip_exp[i]);
            chk($sformatf("%s core_mod[%0d]", tag, i), 32'(core_mod_o[i]), 32'(mod_exp[i]));
            chk($sformatf("%s overrun[%0d]", tag, i), 32'(overrun_o[i]), 32'(ov_exp[i]));
        end
    endtask

    initial begin
        model_reset();
        tick(1);
        do_reset();

        // Reset state
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst dipsw[%0d]", i), dipsw_o[i], 32'hFFFF_FFFF);
            chk($sformatf("rst core_mod[%0d]", i), 32'(core_mod_o[i]), 32'h01);
            chk($sformatf("rst busy[%0d]", i), 32'(busy_o[i]), 32'd0);
            chk($sformatf("rst overrun[%0d]", i), 32'(overrun_o[i]), 32'd0);
            chk($sformatf("rst rom_wr[%0d]", i), 32'(rom_wr_o[i]), 32'd0);
        end

        // ROM word, then unaligned address with bit 25 set
        strobe(8'd0, 27'h100, 32'h0000_BEEF);
        tick(120);
        strobe(8'd0, 27'h200_0203, 32'hA1B2_C3D4);
        tick(120);
        check_regs("rom");

        // DIP bytes
        strobe(8'd254, 27'h0, 32'h1234_5678);
        tick(120);
        check_regs("dip");

        // core_mod, only byte 0 counts
        strobe(8'd1, 27'h0, 32'h0000_7F45);
        tick(120);
        check_regs("mod");

        // Unrouted index: no outputs, same busy window
        strobe(8'd5, 27'h0, 32'hDEAD_BEEF);
        tick(120);
        check_regs("other");

        // Overrun: second strobe 10 cycles after the first
        strobe(8'd0, 27'h40, 32'h5566_7788);
        tick(9);
        strobe(8'd0, 27'h80, 32'h99AA_BBCC);
        tick(120);
        check_regs("ovr");
        download = 1'b0;
        tick(2);
        download = 1'b1;
        for (int i = 0; i < 3; i++) ov_exp[i] = 1'b0;
        tick(3);
        check_regs("ovr_clr");

        // Reset mid-word on the slow 32-bit configuration
        strobe(8'd0, 27'h300, 32'h0403_0201);
        tick(29);
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst busy[2]", 32'(busy_o[2]), 32'd0);
        chk("midrst rom_wr[2]", 32'(rom_wr_o[2]), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(60);
        check_regs("midrst");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
